// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_pkg
//  Description : Shared types and constants for the MIPS CPU fetch path.
//                Holds the reset/halt address defaults, the fetch FSM state
//                encoding and the word/address typedefs, plus a helper that
//                word-aligns an address.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  localparam addr_t RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam addr_t HALT_ADDR_DEFAULT    = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Clears the byte-offset bits; masking keeps every input bit referenced.
  function automatic addr_t word_align(input addr_t a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage : mips_cpu_pkg
`default_nettype wire

// File: rtl/mips_cpu_byteswap32.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_byteswap32
//  Description : Reverses the four byte lanes of a 32-bit word. Used by the
//                fetch unit when instruction memory is little-endian
//                byte-lane organised.
//  Ports       : data_i  in  32  word as delivered by memory
//                data_o  out 32  same word with byte lanes reversed
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_byteswap32
  import mips_cpu_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  assign data_o = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};

endmodule : mips_cpu_byteswap32
`default_nettype wire

// File: rtl/mips_cpu_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_fetch_unit
//  Description : CPU-side initiator of the Harvard instruction-memory port.
//                Owns the PC, applies branch-delay-slot redirects from decode,
//                holds on stalls and halts once the fetch address reaches
//                HALT_ADDR.
//  Build macro : FETCH_BYTESWAP_EN - when defined, instruction words are
//                byte-lane reversed before they are handed to decode.
//  Ports       : clk_i              in  1   system clock, rising edge
//                reset_i            in  1   synchronous active-high reset
//                clk_enable_i       in  1   global enable, 0 freezes state
//                stall_i            in  1   hold PC/state
//                redirect_valid_i   in  1   instr_pc holds a taken branch/jump
//                redirect_target_i  in  32  branch/jump target
//                instr_readdata_i   in  32  memory read data (combinational)
//                instr_address_o    out 32  fetch address (= PC)
//                instr_word_o       out 32  instruction in CPU byte order
//                instr_pc_o         out 32  address of instr_word_o
//                pc_plus8_o         out 32  link value instr_pc + 8
//                instr_valid_o      out 1   instr_word_o executable this cycle
//                active_o           out 1   1 while running, 0 once halted
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_fetch_unit
  import mips_cpu_pkg::*;
#(
  parameter addr_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter addr_t HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_enable_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic [31:0] instr_readdata_i,
  output logic [31:0] instr_address_o,
  output logic [31:0] instr_word_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] pc_plus8_o,
  output logic        instr_valid_o,
  output logic        active_o
);

  fetch_state_t state_q, state_d;
  addr_t        pc_q,    pc_d;
  addr_t        tgt_q,   tgt_d;
  logic         active_q, active_d;
  logic         adv;

  assign adv = clk_enable_i & ~stall_i & (state_q != HALTED);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= RUN;
      pc_q     <= RESET_VECTOR;
      tgt_q    <= '0;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    active_d = active_q;
    if (adv) begin
      if (pc_q == HALT_ADDR) begin
        // Fetching the halt address ends execution; the PC stays parked.
        state_d  = HALTED;
        active_d = 1'b0;
      end else begin
        unique case (state_q)
          RUN: begin
            pc_d = pc_q + 32'd4;
            if (redirect_valid_i) begin
              // Branch seen: fetch the delay slot next, then the target.
              tgt_d   = word_align(redirect_target_i);
              state_d = DELAY;
            end
          end
          DELAY: begin
            // A branch sitting in the delay slot is undefined; ignore it.
            pc_d    = tgt_q;
            state_d = RUN;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  assign instr_address_o = pc_q;
  assign instr_pc_o      = pc_q;
  assign pc_plus8_o      = pc_q + 32'd8;
  assign instr_valid_o   = active_q & (state_q != HALTED) & (pc_q != HALT_ADDR);
  assign active_o        = active_q;

`ifdef FETCH_BYTESWAP_EN
  mips_cpu_byteswap32 u_byteswap (
    .data_i (instr_readdata_i),
    .data_o (instr_word_o)
  );
`else
  assign instr_word_o = instr_readdata_i;
`endif

endmodule : mips_cpu_fetch_unit
`default_nettype wire

// File: tb/tb_mips_cpu_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_fetch_unit
//  Description : Scoreboard bench for mips_cpu_fetch_unit. Stimulus drives
//                each cycle, advances a behavioural fetch model and queues
//                the expected outputs; a monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_cpu_fetch_unit;

  localparam logic [31:0] C_RV     = 32'hBFC0_0000;
  localparam logic [31:0] C_FIXED  = 32'h1B00_A400;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] pc8;
    logic        valid;
    logic        active;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] instr_readdata;
  logic [31:0] instr_address, instr_word, instr_pc, pc_plus8;
  logic        instr_valid, active;
  bit          rd_fixed = 1'b0;

  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;
  exp_t sb[$];

  // Behavioural model: fetch pointer, one pending jump target, halted flag.
  logic [31:0] m_pc = C_RV;
  logic [31:0] m_tgt = '0;
  bit          m_pending = 1'b0;
  bit          m_halted = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit fixed);
    if (fixed) return C_FIXED;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] cpu_order(input logic [31:0] w);
`ifdef FETCH_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always_comb instr_readdata = mem_word(instr_address, rd_fixed);

  mips_cpu_fetch_unit dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .clk_enable_i      (clk_enable),
    .stall_i           (stall),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .instr_readdata_i  (instr_readdata),
    .instr_address_o   (instr_address),
    .instr_word_o      (instr_word),
    .instr_pc_o        (instr_pc),
    .pc_plus8_o        (pc_plus8),
    .instr_valid_o     (instr_valid),
    .active_o          (active)
  );

  // One clock of stimulus; the model moves on the same edge as the DUT.
  task automatic step(input bit r, input bit ce, input bit st, input bit rv,
                      input logic [31:0] t, input bit fixed);
    exp_t e;
    @(negedge clk);
    reset = r; clk_enable = ce; stall = st;
    redirect_valid = rv; redirect_target = t; rd_fixed = fixed;
    @(posedge clk);
    if (r) begin
      m_pc = C_RV; m_pending = 0; m_halted = 0; m_tgt = '0;
    end else if (ce && !st && !m_halted) begin
      if (m_pc == 32'h0) m_halted = 1;
      else if (m_pending) begin
        m_pc = m_tgt; m_pending = 0;
      end else begin
        if (rv) begin
          m_pending = 1;
          m_tgt = {t[31:2], 2'b00};
        end
        m_pc = m_pc + 32'd4;
      end
    end
    e.addr   = m_pc;
    e.pc8    = m_pc + 32'd8;
    e.active = !m_halted;
    e.valid  = !m_halted && (m_pc != 32'h0);
    e.word   = cpu_order(mem_word(m_pc, fixed));
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, 0);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("instr_address", instr_address, e.addr);
        cmp("instr_pc", instr_pc, e.addr);
        cmp("pc_plus8", pc_plus8, e.pc8);
        cmp("instr_word", instr_word, e.word);
        cmp("instr_valid", {31'b0, instr_valid}, {31'b0, e.valid});
        cmp("active", {31'b0, active}, {31'b0, e.active});
      end
    end
  end

  initial begin
    // Reset, stall at BFC00004, then sequential fetch to BFC00018.
    step(1, 1, 0, 0, '0, 0);
    step(1, 1, 0, 0, '0, 0);
    run(1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, '0, 0);
    run(5);
    // jr $0 at BFC00018: delay slot, fetch at 0, then halt and stay halted.
    step(0, 1, 0, 1, 32'h0, 0);
    step(0, 1, 0, 0, '0, 0);
    run(11);
    // Redirect to BFC00100 with a second redirect in the delay slot.
    step(1, 1, 0, 0, '0, 0);
    run(2);
    step(0, 1, 0, 1, 32'hBFC0_0100, 0);
    step(0, 1, 0, 1, 32'hBFC0_0200, 0);
    run(2);
    // Reset while in DELAY, with clk_enable low: pending target is lost.
    step(1, 1, 0, 0, '0, 0);
    run(2);
    step(0, 1, 0, 1, 32'hBFC0_0103, 0);
    step(1, 0, 0, 0, '0, 0);
    run(2);
    // Fixed read data exercises byte ordering; unaligned target masked.
    step(0, 1, 0, 1, 32'hBFC0_0402, 1);
    step(0, 1, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 1);
    run(2);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, ce, st, rv;
      logic [31:0] t;
      r  = ($urandom_range(0, 99) == 0);
      ce = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 4) == 0);
      rv = ($urandom_range(0, 5) == 0);
      t  = ($urandom_range(0, 15) == 0) ? 32'h0 : (C_RV | ($urandom() & 32'h000F_FFFF));
      step(r, ce, st, rv, t, ($urandom_range(0, 9) == 0));
    end
    stim_done = 1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mips_cpu_fetch_unit
`default_nettype wire
